// File: rtl/capture_pkg.sv
// Shared state encoding, trigger-mode codes and default sizes for the
// record capture sequencer.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ARMED,
        CAPTURE
    } seq_state_t;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_SOF       = 2'd1;
    localparam logic [1:0] TRIG_EXT       = 2'd2;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/capture_fifo.sv
// Registered-output word FIFO with wrap-bit pointers; a push is accepted
// while full only when a pop frees the head slot on the same edge.
module capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign popData = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetN) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: contents are only visible while not empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/record_sequencer.sv
// Capture controller: arm, wait for trigger, enable the recorder for N words
// and queue each completed word. Define CAPTURE_TIMESTAMP_EN for trigStamp.
module record_sequencer
    import capture_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       trigMode,
    input  logic [CNT_W-1:0] wordCount,
    input  logic             busIn,
    input  logic             extTrig,
    output logic             recEnable,
    output logic             recResetN,
    input  logic [31:0]      recData,
    input  logic             recValid,
    output logic [31:0]      outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] wordsCaptured,
    output logic [31:0]      trigStamp
);

    seq_state_t       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busIn_q, recValid_q;
    logic             strobe, trig, push, fifo_full, fifo_empty;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= IDLE;
            mode_q     <= TRIG_IMMEDIATE;
            target_q   <= '0;
            words_q    <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            busIn_q    <= 1'b1;
            recValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            words_q    <= words_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            busIn_q    <= busIn;
            recValid_q <= recValid;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        words_d  = words_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        trig     = 1'b0;
        push     = 1'b0;
        // A word completes on the falling edge of the recorder's valid level.
        strobe   = (state_q == CAPTURE) && recValid_q && !recValid;

        if (strobe) begin
            if (words_q != {CNT_W{1'b1}}) words_d = words_q + CNT_W'(1);
            if (fifo_full) ovf_d = 1'b1;
            else           push  = 1'b1;
        end

        case (mode_q)
            TRIG_SOF: trig = busIn_q && !busIn;
            TRIG_EXT: trig = extTrig;
            default:  trig = 1'b1;
        endcase

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = CLEAR;
                    words_d  = '0;
                    ovf_d    = 1'b0;
                    mode_d   = trigMode;
                    target_d = wordCount;
                end
            end
            CLEAR:   state_d = ARMED;
            ARMED:   if (trig) state_d = CAPTURE;
            CAPTURE: begin
                if (strobe && (target_q != '0) && (words_d == target_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    capture_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetN   (resetN),
        .push     (push),
        .pushData (recData),
        .full     (fifo_full),
        .pop      (outReady),
        .popData  (outData),
        .empty    (fifo_empty)
    );

    assign outValid      = !fifo_empty;
    assign recEnable     = (state_q == CAPTURE);
    assign recResetN     = resetN & (state_q != CLEAR);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign wordsCaptured = words_q;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] cyc_q, stamp_q;
    logic        enter_cap;

    assign enter_cap = (state_q == ARMED) && (state_d == CAPTURE);

    // The stamp is the counter value that holds after the trigger edge.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cyc_q   <= '0;
            stamp_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (enter_cap) stamp_q <= cyc_q + 32'd1;
        end
    end
    assign trigStamp = stamp_q;
`else
    assign trigStamp = '0;
`endif

endmodule

// File: tb/tb_record_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based behavioural model.
module tb_record_sequencer;

    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int MAXW  = (1 << CW) - 1;

    logic          clk = 1'b0, resetN = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0]    trigMode = 2'd0;
    logic [CW-1:0] wordCount = '0;
    logic          busIn = 1'b1, extTrig = 1'b0, recValid = 1'b0, outReady = 1'b0;
    logic [31:0]   recData = '0;
    logic          recEnable, recResetN, outValid, busy, done, overflow;
    logic [31:0]   outData, trigStamp;
    logic [CW-1:0] wordsCaptured;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    record_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .resetN(resetN), .start(start), .abort(abort),
        .trigMode(trigMode), .wordCount(wordCount), .busIn(busIn),
        .extTrig(extTrig), .recEnable(recEnable), .recResetN(recResetN),
        .recData(recData), .recValid(recValid), .outData(outData),
        .outValid(outValid), .outReady(outReady), .busy(busy), .done(done),
        .overflow(overflow), .wordsCaptured(wordsCaptured), .trigStamp(trigStamp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 clear, 2 armed, 3 capturing.
    int          m_ph = 0, m_mode = 0, m_target = 0, m_wc = 0;
    bit          m_ovf = 0, m_done = 0, m_bprev = 1, m_vprev = 0;
    bit          s_strobe, s_full, s_pop, s_push;
    logic [31:0] m_cnt = 0, m_stamp = 0, exp_stamp;
    logic [31:0] m_q[$];
    logic [31:0] dut_pops[$];
    logic [31:0] dd;
    bit          dv = 0, chk_en = 0;
    int          done_cnt = 0, clr_cnt = 0;

    always begin
        @(posedge clk);
        if (dv && outReady) dut_pops.push_back(dd);
        if (!resetN) begin
            m_ph = 0; m_wc = 0; m_ovf = 0; m_done = 0; m_q.delete();
            m_cnt = 0; m_stamp = 0; m_bprev = 1; m_vprev = 0;
        end else begin
            m_cnt++;
            m_done   = 0;
            s_strobe = (m_ph == 3) && m_vprev && !recValid;
            s_full   = (m_q.size() == DEPTH);
            s_pop    = (m_q.size() != 0) && outReady;
            s_push   = 0;
            if (s_strobe) begin
                if (m_wc < MAXW) m_wc++;
                if (s_full) m_ovf = 1; else s_push = 1;
            end
            if (m_ph != 0 && abort) m_ph = 0;
            else case (m_ph)
                0: if (start) begin
                       m_ph = 1; m_wc = 0; m_ovf = 0;
                       m_mode = int'(trigMode); m_target = int'(wordCount);
                   end
                1: m_ph = 2;
                2: if (m_mode == 0 || m_mode == 3 || (m_mode == 1 && m_bprev && !busIn) ||
                       (m_mode == 2 && extTrig)) begin
                       m_ph = 3; m_stamp = m_cnt;
                   end
                default: if (s_strobe && m_target != 0 && m_wc == m_target) begin
                       m_ph = 0; m_done = 1;
                   end
            endcase
            if (s_pop)  m_q.delete(0);
            if (s_push) m_q.push_back(recData);
            m_bprev = busIn;
            m_vprev = recValid;
        end
        #1;
        dv = outValid; dd = outData;
        if (done) done_cnt++;
        if (!recResetN) clr_cnt++;
`ifdef CAPTURE_TIMESTAMP_EN
        exp_stamp = m_stamp;
`else
        exp_stamp = 32'd0;
`endif
        if (chk_en) begin
            chk("recEnable", {31'd0, recEnable}, {31'd0, m_ph == 3});
            chk("recResetN", {31'd0, recResetN}, {31'd0, resetN && m_ph != 1});
            chk("busy", {31'd0, busy}, {31'd0, m_ph != 0});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("wordsCaptured", {16'd0, wordsCaptured}, m_wc);
            chk("outValid", {31'd0, outValid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) chk("outData", outData, m_q[0]);
            chk("trigStamp", trigStamp, exp_stamp);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [1:0] mode, input logic [CW-1:0] cnt);
        @(negedge clk); trigMode = mode; wordCount = cnt; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic word(input logic [31:0] d);
        @(negedge clk); recValid = 1'b1;
        @(negedge clk);
        @(negedge clk); recValid = 1'b0; recData = d;
        @(negedge clk);
    endtask

    logic [31:0] sent[10];
    int          d0, guard;

    initial begin
        @(negedge clk); chk_en = 1;
        @(negedge clk); resetN = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_outValid", {31'd0, outValid}, 32'd0);
        chk("reset_words", {16'd0, wordsCaptured}, 32'd0);
        chk("reset_stamp", trigStamp, 32'd0);

        // 1: immediate, two words, host always ready
        outReady = 1'b1; dut_pops.delete(); d0 = done_cnt; clr_cnt = 0;
        pulse_start(2'd0, 16'd2);
        tick(3);
        word(32'hDEADBEEF);
        word(32'h12345678);
        tick(4);
        chk("t1_pops", dut_pops.size(), 32'd2);
        if (dut_pops.size() == 2) begin
            chk("t1_word0", dut_pops[0], 32'hDEADBEEF);
            chk("t1_word1", dut_pops[1], 32'h12345678);
        end
        chk("t1_done", done_cnt - d0, 32'd1);
        chk("t1_clear", clr_cnt, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_words", {16'd0, wordsCaptured}, 32'd2);

        // 2: start-of-frame, edge during CLEAR ignored
        busIn = 1'b1;
        @(negedge clk); trigMode = 2'd1; wordCount = 16'd4; start = 1'b1;
        @(negedge clk); start = 1'b0; busIn = 1'b0;
        @(negedge clk); busIn = 1'b1;
        tick(20);
        chk("t2_before", {31'd0, recEnable}, 32'd0);
        busIn = 1'b0;
        @(negedge clk);
        chk("t2_after", {31'd0, recEnable}, 32'd1);
        busIn = 1'b1; abort = 1'b1;
        @(negedge clk); abort = 1'b0;

        // 3: overflow with a stalled host, then drain
        outReady = 1'b0; d0 = done_cnt;
        pulse_start(2'd0, 16'd10);
        tick(3);
        for (int i = 0; i < 10; i++) begin
            sent[i] = $urandom;
            word(sent[i]);
            if (i == 7) chk("t3_ovf8", {31'd0, overflow}, 32'd0);
            if (i == 8) chk("t3_ovf9", {31'd0, overflow}, 32'd1);
        end
        tick(2);
        chk("t3_words", {16'd0, wordsCaptured}, 32'd10);
        chk("t3_done", done_cnt - d0, 32'd1);
        dut_pops.delete();
        outReady = 1'b1;
        tick(12);
        chk("t3_drained", dut_pops.size(), 32'd8);
        for (int i = 0; i < 8 && i < dut_pops.size(); i++) chk("t3_order", dut_pops[i], sent[i]);
        chk("t3_outValid", {31'd0, outValid}, 32'd0);

        // 4: continuous capture ended by abort coinciding with a strobe and a start
        outReady = 1'b0; d0 = done_cnt;
        pulse_start(2'd3, 16'd0);
        tick(3);
        for (int i = 0; i < 5; i++) word(32'hA000_0000 + i);
        @(negedge clk); recValid = 1'b1;
        @(negedge clk);
        @(negedge clk); recValid = 1'b0; recData = 32'hA000_0005; abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        chk("t4_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t4_start_dropped", {31'd0, busy}, 32'd0);
        chk("t4_no_done", done_cnt - d0, 32'd0);
        dut_pops.delete(); outReady = 1'b1;
        tick(10);
        chk("t4_six", dut_pops.size(), 32'd6);
        if (dut_pops.size() == 6) chk("t4_last", dut_pops[5], 32'hA000_0005);

        // 5: reset in the middle of a capture
        outReady = 1'b0;
        pulse_start(2'd0, 16'd0);
        tick(3);
        for (int i = 0; i < 3; i++) word($urandom);
        chk("t5_queued", {31'd0, outValid}, 32'd1);
        @(negedge clk); resetN = 1'b0;
        @(negedge clk); resetN = 1'b1;
        chk("t5_outValid", {31'd0, outValid}, 32'd0);
        chk("t5_recEnable", {31'd0, recEnable}, 32'd0);
        chk("t5_words", {16'd0, wordsCaptured}, 32'd0);
        chk("t5_ovf", {31'd0, overflow}, 32'd0);

        // 6: external trigger raised while the cycle counter reads 100
        pulse_start(2'd2, 16'd0);
        guard = 0;
        while (m_cnt != 32'd100 && guard < 500) begin @(negedge clk); guard++; end
        chk("t6_wait", {31'd0, guard < 500}, 32'd1);
        extTrig = 1'b1;
        @(negedge clk); extTrig = 1'b0;
        chk("t6_enable", {31'd0, recEnable}, 32'd1);
`ifdef CAPTURE_TIMESTAMP_EN
        chk("t6_stamp", trigStamp, 32'd101);
`else
        chk("t6_stamp", trigStamp, 32'd0);
`endif
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            resetN    = ($urandom_range(999) >= 2);
            start     = ($urandom_range(99) < 6);
            abort     = ($urandom_range(199) < 2);
            trigMode  = 2'($urandom_range(3));
            wordCount = CW'($urandom_range(12));
            if ($urandom_range(9) == 0) busIn = ~busIn;
            extTrig   = ($urandom_range(99) < 5);
            if ($urandom_range(9) < 3) recValid = ~recValid;
            recData   = $urandom;
            outReady  = ($urandom_range(99) < 40);
        end
        @(negedge clk);
        resetN = 1'b1; start = 1'b0; abort = 1'b0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/record_sequencer.md
Name: record_sequencer

Overview:
Capture controller for the 32-bit CAN bit-recording datapath. It arms on a host start, waits for a selectable trigger, then enables the recorder for a programmed number of 32-bit words. Each completed word is pushed into a small output FIFO with a valid/ready interface toward the host/UART side. It also provides a per-capture recorder clear so that word alignment restarts on every capture.

Parameters:
FIFO_DEPTH, 8, output FIFO entries (power of two, at least 2)
CNT_W, 16, width of the word-count and captured-count fields

Ports:
clk  in  1  system clock
resetN  in  1  reset; one clock; reset is synchronous and active-low
start  in  1  single-cycle request to arm a capture
abort  in  1  single-cycle request to stop the capture
trigMode  in  2  0 = immediate, 1 = start-of-frame (busIn falling edge), 2 = extTrig high, 3 = immediate
wordCount  in  CNT_W  words to capture; 0 = continuous until abort
busIn  in  1  synchronized CAN RX, the same signal as the recorder data input
extTrig  in  1  external trigger level
recEnable  out  1  recorder enable
recResetN  out  1  recorder clear, active-low; ANDed with resetN at the top level
recData  in  32  recorder word output
recValid  in  1  recorder data-valid level
outData  out  32  FIFO head word
outValid  out  1  FIFO not empty
outReady  in  1  host accepts the head word
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when capture completes normally
overflow  out  1  sticky; set when a word is dropped because the FIFO is full
wordsCaptured  out  CNT_W  words accepted from the recorder in the current capture
trigStamp  out  32  cycle count latched at trigger (see Optional Feature)

Behaviour:
- Reset values: recEnable = 0, recResetN = 1, busy = 0, done = 0, overflow = 0, wordsCaptured = 0, trigStamp = 0, FIFO empty (outValid = 0). outData is don't-care while outValid = 0.
- All state transitions, outputs and FIFO updates are registered.
- States: IDLE, CLEAR, ARMED, CAPTURE.
- IDLE:
  - start goes to CLEAR.
  - On the same edge, wordsCaptured and overflow are cleared and trigMode and wordCount are latched.
  - start while busy is ignored.
- CLEAR: lasts exactly one cycle with recResetN = 0, then goes to ARMED.
- ARMED:
  - Immediate mode (0 or 3): goes to CAPTURE on the next cycle.
  - Mode 1: goes to CAPTURE on the cycle after busIn changes 1 to 0, using a registered busIn_d. busIn_d updates every cycle, and an edge seen during CLEAR is ignored.
  - Mode 2: goes to CAPTURE on the cycle after extTrig is sampled high.
- CAPTURE:
  - recEnable = 1.
  - A word-complete strobe is recValid_d = 1 and recValid = 0 (recValid falling edge). recData is stable on that cycle.
  - On each strobe: wordsCaptured increments (saturating at all-ones), and recData is written to the FIFO unless it is full.
  - If the FIFO is full, the word is dropped and overflow is set.
- Completion:
  - Applies when wordCount != 0 and the strobe makes wordsCaptured equal to wordCount.
  - On the next cycle: state = IDLE, recEnable = 0, done = 1 for one cycle.
- abort, in any non-IDLE state:
  - Next cycle: state = IDLE and recEnable = 0.
  - No done pulse. FIFO contents and overflow are retained.
  - A strobe coinciding with abort is still written.
  - abort and start in the same cycle: abort wins and start is dropped.
- FIFO:
  - A push and a pop in the same cycle are both legal while full or non-empty.
  - When empty, a push makes outValid rise on the next cycle (no fall-through).
  - Pop occurs when outValid and outReady are both high.
  - Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for full/empty.
- Reset mid-capture returns everything to its reset values on the next edge.

Optional Feature:
CAPTURE_TIMESTAMP_EN:
- Defined:
  - A 32-bit free-running cycle counter (reset 0, wraps) is included.
  - trigStamp latches the counter on the ARMED-to-CAPTURE transition.
  - trigStamp holds until the next trigger or reset.
- Undefined: no counter is built and trigStamp is tied to 0.

Decomposition:
- capture_pkg, shared package:
  - seq_state_t enum (IDLE, CLEAR, ARMED, CAPTURE).
  - TRIG_IMMEDIATE = 0, TRIG_SOF = 1, TRIG_EXT = 2.
  - Default constants for FIFO_DEPTH and CNT_W.
- One sub-module: capture_fifo.
  - Parameterised width and depth, synchronous active-low reset.
  - Ports: push, pushData, full, pop, popData, empty.
- The FSM, strobe detection, counters and timestamp stay in record_sequencer.

Test Plan:
1. Immediate, count of 2:
   - Stimulus: trigMode = 0, wordCount = 2, start; feed two recValid falling edges with recData = 0xDEADBEEF then 0x12345678; hold outReady = 1.
   - Required: recResetN low for exactly 1 cycle; recEnable high from CAPTURE entry; outData presents 0xDEADBEEF then 0x12345678; done pulses once; busy drops; wordsCaptured = 2.
2. Start-of-frame trigger:
   - Stimulus: trigMode = 1, busIn held 1 for 20 cycles, then driven to 0.
   - Required: recEnable stays 0 until 1 cycle after the falling edge; a falling edge during CLEAR does not trigger.
3. Overflow:
   - Stimulus: FIFO_DEPTH = 8, outReady = 0, wordCount = 10, ten strobes.
   - Required: 8 words stored; overflow = 1 after the 9th strobe; wordsCaptured = 10; done pulses.
   - Then raise outReady: the 8 words drain in order and outValid falls.
4. Continuous with abort:
   - Stimulus: wordCount = 0, five strobes, then abort together with a sixth strobe and a start.
   - Required: six words in the FIFO; no done; IDLE on the next cycle; start ignored.
5. Reset mid-capture:
   - Stimulus: resetN = 0 for 1 cycle in CAPTURE with 3 words queued.
   - Required: outValid = 0, recEnable = 0, wordsCaptured = 0, overflow = 0.
6. CAPTURE_TIMESTAMP_EN defined:
   - Stimulus: trigMode = 2, extTrig raised at counter value 100.
   - Required: trigStamp = 101, the value on the transition edge.
   - Macro undefined: trigStamp = 0 throughout.
